global_buffer_io_controller: RTL and testbench

- Front-end stage that sits directly upstream of the PE-array controller (controller_PE_generator) and shares the same global buffer.
- Accepts an external valid/ready word stream and writes it into the lower half of the global buffer (filters, then ifmaps, in the address order the PE controller reads).
- Issues a one-cycle Start pulse to the PE controller and waits for its done.
- Drains the result words from the upper half of the buffer onto a valid/ready output stream.

---
 rtl/global_buffer_io_controller.sv | 156 +++++++++++++++
 tb/tb_global_buffer_io_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/global_buffer_io_controller.sv
// Front-end for the PE-array controller: streams input words into the lower half of
// the global buffer, kicks the PE controller, then drains results from the upper half.
// Optional LOAD_CHECKSUM_EN adds a running sum of the loaded words on load_checksum.
module global_buffer_io_controller #(
  parameter int GLOBAL_BUFFER_ADDR_WIDTH = 6,
  parameter int GLOBAL_BUFFER_DEPTH      = 64,
  parameter int DATA_WIDTH               = 16,
  parameter int COUNT_WIDTH              = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_load,
  input  logic [COUNT_WIDTH-1:0]              load_count,
  input  logic [COUNT_WIDTH-1:0]              result_count,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                wen_global_buffer,
  output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] waddr_global_buffer,
  output logic [DATA_WIDTH-1:0]               wdata_global_buffer,
  output logic                                ren_global_buffer,
  output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] raddr_global_buffer,
  input  logic [DATA_WIDTH-1:0]               rdata_global_buffer,
  output logic                                Start,
  input  logic                                done_in,
  output logic                                compute_phase,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH+COUNT_WIDTH-1:0]   load_checksum
`endif
);

  localparam int RBASE = (GLOBAL_BUFFER_DEPTH + 1) / 2;
  localparam logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] RBASE_A = GLOBAL_BUFFER_ADDR_WIDTH'(RBASE);
  localparam logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] LAST_A  = GLOBAL_BUFFER_ADDR_WIDTH'(GLOBAL_BUFFER_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_COMPUTE, S_RD, S_RD_WAIT, S_OUT, S_DONE
  } state_t;

  state_t                              state_q, state_d;
  logic [COUNT_WIDTH-1:0]              ld_cnt_q, ld_cnt_d;
  logic [COUNT_WIDTH-1:0]              ld_total_q, ld_total_d;
  logic [COUNT_WIDTH-1:0]              res_cnt_q, res_cnt_d;
  logic [COUNT_WIDTH-1:0]              res_total_q, res_total_d;
  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]               out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0]              ld_clamp;
  logic                                accept;
`ifdef LOAD_CHECKSUM_EN
  logic [DATA_WIDTH+COUNT_WIDTH-1:0]   csum_q, csum_d;
`endif

  // Loads may only fill the lower half; the upper half belongs to results.
  assign ld_clamp = (int'(load_count) > RBASE) ? COUNT_WIDTH'(RBASE) : load_count;
  assign accept   = (state_q == S_LOAD) && in_valid;

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    ld_total_d  = ld_total_q;
    res_cnt_d   = res_cnt_q;
    res_total_d = res_total_q;
    raddr_d     = raddr_q;
    out_data_d  = out_data_q;
`ifdef LOAD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: if (start_load) begin
        ld_total_d  = ld_clamp;
        res_total_d = result_count;
        ld_cnt_d    = '0;
`ifdef LOAD_CHECKSUM_EN
        csum_d      = '0;
`endif
        state_d     = (ld_clamp == '0) ? S_KICK : S_LOAD;
      end
      S_LOAD: if (accept) begin
        ld_cnt_d = ld_cnt_q + COUNT_WIDTH'(1);
`ifdef LOAD_CHECKSUM_EN
        csum_d   = csum_q + (DATA_WIDTH+COUNT_WIDTH)'(in_data);
`endif
        if (ld_cnt_q == ld_total_q - COUNT_WIDTH'(1)) state_d = S_KICK;
      end
      S_KICK: state_d = S_COMPUTE;
      S_COMPUTE: if (done_in) begin
        raddr_d   = RBASE_A;
        res_cnt_d = '0;
        state_d   = (res_total_q == '0) ? S_DONE : S_RD;
      end
      S_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        out_data_d = rdata_global_buffer;
        state_d    = S_OUT;
      end
      S_OUT: if (out_ready) begin
        // Result region is a ring over the upper half of the buffer.
        raddr_d   = (raddr_q == LAST_A) ? RBASE_A : raddr_q + GLOBAL_BUFFER_ADDR_WIDTH'(1);
        res_cnt_d = res_cnt_q + COUNT_WIDTH'(1);
        state_d   = (res_cnt_q == res_total_q - COUNT_WIDTH'(1)) ? S_DONE : S_RD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      ld_total_q  <= '0;
      res_cnt_q   <= '0;
      res_total_q <= '0;
      raddr_q     <= '0;
      out_data_q  <= '0;
`ifdef LOAD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      ld_total_q  <= ld_total_d;
      res_cnt_q   <= res_cnt_d;
      res_total_q <= res_total_d;
      raddr_q     <= raddr_d;
      out_data_q  <= out_data_d;
`ifdef LOAD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Address/data buses are gated so they read zero whenever the strobe is low.
  assign in_ready            = (state_q == S_LOAD);
  assign wen_global_buffer   = accept;
  assign waddr_global_buffer = accept ? GLOBAL_BUFFER_ADDR_WIDTH'(ld_cnt_q) : '0;
  assign wdata_global_buffer = accept ? in_data : '0;
  assign ren_global_buffer   = (state_q == S_RD);
  assign raddr_global_buffer = (state_q == S_RD) ? raddr_q : '0;
  assign Start               = (state_q == S_KICK);
  assign compute_phase       = (state_q == S_KICK) || (state_q == S_COMPUTE);
  assign out_data            = out_data_q;
  assign out_valid           = (state_q == S_OUT);
  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_DONE);
`ifdef LOAD_CHECKSUM_EN
  assign load_checksum       = csum_q;
`endif

endmodule

// File: tb/tb_global_buffer_io_controller.sv
// Scoreboard bench: expected writes, reads and result words are queued as stimulus is
// driven and popped by a negedge monitor as the controller produces them.
module tb_global_buffer_io_controller;
  localparam int AW = 6, DW = 16, CW = 6, DEPTH = 64, RB = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_load = 1'b0;
  logic [CW-1:0] load_count = '0, result_count = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wen;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata = '0, out_data;
  logic          ren, Start, done_in = 1'b0, compute_phase;
  logic          out_valid, out_ready = 1'b0, busy, done;
`ifdef LOAD_CHECKSUM_EN
  logic [DW+CW-1:0] load_checksum;
`endif

  global_buffer_io_controller #(
    .GLOBAL_BUFFER_ADDR_WIDTH(AW), .GLOBAL_BUFFER_DEPTH(DEPTH),
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .load_count(load_count),
    .result_count(result_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wen_global_buffer(wen), .waddr_global_buffer(waddr),
    .wdata_global_buffer(wdata), .ren_global_buffer(ren), .raddr_global_buffer(raddr),
    .rdata_global_buffer(rdata), .Start(Start), .done_in(done_in),
    .compute_phase(compute_phase), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
`ifdef LOAD_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    words [64];
  logic [AW+DW-1:0] wq [$];
  logic [AW-1:0]    rq [$];
  logic [DW-1:0]    oq [$];
  int n_cmp = 0, n_fail = 0, start_cnt = 0, done_cnt = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) begin
    if (ren) rdata <= mem[raddr];
    if (wen) mem[waddr] <= wdata;
  end

  always @(negedge clk) begin
    if (rst) prev_hold = 1'b0;
    else begin
      if (wen) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_fail++; $display("FAIL unexpected_write: got addr %0d data %h, required none", waddr, wdata);
        end else begin
          logic [AW+DW-1:0] e; e = wq.pop_front();
          if ({waddr, wdata} !== e) begin
            n_fail++; $display("FAIL write: got %0d/%h required %0d/%h", waddr, wdata, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
      if (ren) begin
        n_cmp++;
        if (rq.size() == 0) begin
          n_fail++; $display("FAIL unexpected_read: got addr %0d, required none", raddr);
        end else begin
          logic [AW-1:0] e; e = rq.pop_front();
          if (raddr !== e) begin n_fail++; $display("FAIL read_addr: got %0d required %0d", raddr, e); end
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (oq.size() == 0) begin
          n_fail++; $display("FAIL unexpected_out: got %h, required none", out_data);
        end else begin
          logic [DW-1:0] e; e = oq.pop_front();
          if (out_data !== e) begin n_fail++; $display("FAIL out_data: got %h required %h", out_data, e); end
        end
      end
      if (prev_hold) begin
        n_cmp++;
        if (out_data !== prev_data) begin
          n_fail++; $display("FAIL out_stable: got %h required %h", out_data, prev_data);
        end
      end
      if (Start) start_cnt++;
      if (done) done_cnt++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic do_abort(input string name, input int d0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, wen, waddr, wdata, ren, raddr, Start, compute_phase, out_data, out_valid, busy, done} !== '0) begin
      n_fail++; $display("FAIL %s_outputs_zero: got in_ready=%b wen=%b ren=%b Start=%b cp=%b out=%h ov=%b busy=%b done=%b, required all 0",
        name, in_ready, wen, ren, Start, compute_phase, out_data, out_valid, busy, done);
    end
    rst = 1'b0;
    wq.delete(); rq.delete(); oq.delete();
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_no_done: got done pulses %0d busy %b, required 0 and 0", name, done_cnt - d0, busy);
    end
  endtask

  // abort: 0 none, 1 reset after the third load word, 2 reset while the first result waits
  task automatic run_job(input string name, input int ld_n, input int res_n, input bit tog,
                         input int stall, input int dly, input int abort);
    int eff, s0, d0, k;
    eff = (ld_n > RB) ? RB : ld_n;
    s0 = start_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    done_in = 1'b1;                 // done_in outside COMPUTE must be ignored
    @(posedge clk); #1;
    done_in = 1'b0; start_load = 1'b1; load_count = CW'(ld_n); result_count = CW'(res_n);
    @(posedge clk); #1;
    start_load = 1'b0;
    for (int i = 0; i < eff; i++) begin
      wq.push_back({AW'(i), words[i]});
      in_data = words[i]; in_valid = 1'b1;
      k = 0; @(negedge clk);
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      if (!in_ready) begin
        n_cmp++; n_fail++; $display("FAIL %s_load_timeout: got in_ready 0, required 1", name);
        in_valid = 1'b0; return;
      end
      @(posedge clk); #1;
      if (abort == 1 && i == 2) begin do_abort(name, d0); return; end
      if (tog && i < eff - 1) begin in_valid = 1'b0; @(posedge clk); #1; end
    end
    in_data = 16'hDEAD; in_valid = 1'b1;   // extra words must never be accepted
    for (int j = 0; j < res_n; j++) begin
      rq.push_back(AW'(RB + (j % RB)));
      oq.push_back(mem[RB + (j % RB)]);
    end
    k = 0; @(negedge clk);
    while (!Start && k < 50) begin @(negedge clk); k++; end
    if (!Start) begin n_cmp++; n_fail++; $display("FAIL %s_start_timeout: got Start 0, required 1", name); return; end
    @(posedge clk); #1;
    start_load = 1'b1; load_count = 6'd5; result_count = 6'd1;   // busy: must be ignored
    @(posedge clk); #1;
    start_load = 1'b0;
    repeat (dly) @(posedge clk);
    #1 done_in = 1'b1;
    @(posedge clk); #1 done_in = 1'b0;
    out_ready = (stall == 0);
    for (int j = 0; j < res_n; j++) begin
      k = 0; @(negedge clk);
      while (!out_valid && k < 50) begin @(negedge clk); k++; end
      if (!out_valid) begin n_cmp++; n_fail++; $display("FAIL %s_out_timeout: got out_valid 0, required 1", name); return; end
      if (abort == 2) begin do_abort(name, d0); return; end
      if (stall > 0) begin
        repeat (stall) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    k = 0; @(negedge clk);
    while (!done && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (!done) begin n_fail++; $display("FAIL %s_done_timeout: got done 0, required 1", name); return; end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_fall: got busy %b done %b, required 0 0", name, busy, done);
    end
    n_cmp++;
    if (start_cnt - s0 != 1 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL %s_pulses: got Start %0d done %0d, required 1 1", name, start_cnt - s0, done_cnt - d0);
    end
    n_cmp++;
    if (wq.size() != 0 || rq.size() != 0 || oq.size() != 0) begin
      n_fail++; $display("FAIL %s_leftover: got %0d/%0d/%0d pending, required 0", name, wq.size(), rq.size(), oq.size());
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, wen, ren, Start, compute_phase, out_data, out_valid, busy, done} !== '0) begin
      n_fail++; $display("FAIL reset_state: got busy=%b out=%h Start=%b, required all 0", busy, out_data, Start);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) words[i] = DW'(i + 1);
    for (int a = 0; a < 4; a++) mem[RB + a] = DW'(16'h000A + a);
    run_job("basic", 8, 4, 1'b0, 0, 10, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) words[i] = DW'(16'h1100 + i * 7);
    run_job("backpressure", 8, 4, 1'b1, 5, 3, 0);
  endtask

  task automatic test_zero_counts();
    run_job("zero", 0, 0, 1'b0, 0, 4, 0);
  endtask

  task automatic test_clamp_wrap();
    for (int i = 0; i < 40; i++) words[i] = DW'($urandom_range(0, 16'hFFFF));
    run_job("clamp_wrap", 40, 35, 1'b0, 0, 4, 0);
  endtask

  task automatic test_reset_mid_job();
    for (int i = 0; i < 8; i++) words[i] = DW'(16'h2200 + i);
    run_job("abort_load", 8, 4, 1'b0, 0, 5, 1);
    run_job("abort_out", 6, 3, 1'b0, 2, 5, 2);
    for (int i = 0; i < 5; i++) words[i] = DW'(16'h3300 + i);
    run_job("after_abort", 5, 3, 1'b0, 1, 6, 0);
  endtask

`ifdef LOAD_CHECKSUM_EN
  task automatic test_checksum();
    words[0] = 16'h0001; words[1] = 16'hFFFF; words[2] = 16'h0010;
    run_job("checksum", 3, 1, 1'b0, 0, 3, 0);
    n_cmp++;
    if (load_checksum !== 22'h10010) begin
      n_fail++; $display("FAIL checksum: got %h required %h", load_checksum, 22'h10010);
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(16'hA000 | a);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_counts();
    test_clamp_wrap();
    test_reset_mid_job();
`ifdef LOAD_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
